// File: rtl/natv_bus_pkg.sv
// ---------------------------------------------------------------------------
// natv_bus_pkg
// Shared types and constants for the natv bus router:
//   state_e      - router FSM states (IDLE / REQ / RESP)
//   err_cause_e  - sticky error cause encoding (none / miss / timeout)
//   DEF_RDATA    - read data returned on decode miss or slave timeout
//   DEF_SLV_BASE / DEF_SLV_MASK - default four-slave address map
// ---------------------------------------------------------------------------
package natv_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_MISS    = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_cause_e;

    localparam logic [31:0] DEF_RDATA   = 32'hDEAD_BEEF;
    localparam int          DEF_NUM_SLV = 4;

    localparam logic [31:0] DEF_SLV_BASE [DEF_NUM_SLV] = '{
        32'h0000_0000, 32'h0300_0000, 32'h0400_0000, 32'h0800_0000
    };

    localparam logic [31:0] DEF_SLV_MASK [DEF_NUM_SLV] = '{
        32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF80_0000
    };

endpackage

// File: rtl/natv_bus_router_if.sv
// ---------------------------------------------------------------------------
// natv_bus_router_if
// Bundles the core-side request/response, the shared slave request fields,
// the per-slave responses and the error reporting signals of the router.
//   modport slave  - the router's view (takes core requests, drives slaves)
//   modport master - the environment's view (core master plus slave models)
// ---------------------------------------------------------------------------
interface natv_bus_router_if #(
    parameter int NUM_SLV = 4
);
    // core side
    logic                      core_valid_i;
    logic [31:0]               core_addr_i;
    logic [31:0]               core_wdata_i;
    logic [3:0]                core_wstrb_i;
    logic [31:0]               core_rdata_o;
    logic                      core_ready_o;
    // slave side
    logic [NUM_SLV-1:0]        slv_valid_o;
    logic [31:0]               slv_addr_o;
    logic [31:0]               slv_wdata_o;
    logic [3:0]                slv_wstrb_o;
    logic [NUM_SLV-1:0][31:0]  slv_rdata_i;
    logic [NUM_SLV-1:0]        slv_ready_i;
    // error reporting
    logic                      err_o;
    logic [31:0]               err_addr_o;
    logic [1:0]                err_cause_o;
    logic                      err_clr_i;

    modport slave (
        input  core_valid_i, core_addr_i, core_wdata_i, core_wstrb_i,
        output core_rdata_o, core_ready_o,
        output slv_valid_o, slv_addr_o, slv_wdata_o, slv_wstrb_o,
        input  slv_rdata_i, slv_ready_i,
        output err_o, err_addr_o, err_cause_o,
        input  err_clr_i
    );

    modport master (
        output core_valid_i, core_addr_i, core_wdata_i, core_wstrb_i,
        input  core_rdata_o, core_ready_o,
        input  slv_valid_o, slv_addr_o, slv_wdata_o, slv_wstrb_o,
        output slv_rdata_i, slv_ready_i,
        input  err_o, err_addr_o, err_cause_o,
        output err_clr_i
    );

endinterface

// File: rtl/natv_bus_addr_dec.sv
// ---------------------------------------------------------------------------
// natv_bus_addr_dec
// Combinational address decoder. A slave k matches when
// (addr & SLV_MASK[k]) == SLV_BASE[k]; the lowest matching index wins.
//   addr - request address
//   hit  - one-hot vector of the winning slave (all zero on miss)
//   idx  - encoded index of the winning slave (zero on miss)
//   miss - no slave matched
// ---------------------------------------------------------------------------
module natv_bus_addr_dec #(
    parameter int          NUM_SLV = 4,
    parameter logic [31:0] SLV_BASE [NUM_SLV] = natv_bus_pkg::DEF_SLV_BASE,
    parameter logic [31:0] SLV_MASK [NUM_SLV] = natv_bus_pkg::DEF_SLV_MASK
) (
    input  logic [31:0]                  addr,
    output logic [NUM_SLV-1:0]           hit,
    output logic [$clog2(NUM_SLV)-1:0]   idx,
    output logic                         miss
);
    localparam int IDX_W = $clog2(NUM_SLV);

    // Priority match: scan upward and keep only the first match found.
    always_comb begin
        hit  = '0;
        idx  = '0;
        miss = 1'b1;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (miss && ((addr & SLV_MASK[k]) == SLV_BASE[k])) begin
                hit[k] = 1'b1;
                idx    = IDX_W'(k);
                miss   = 1'b0;
            end else begin
                // a lower index already won, or this slave does not match
            end
        end
    end

endmodule

// File: rtl/natv_bus_router.sv
// ---------------------------------------------------------------------------
// natv_bus_router
// Routes one core request at a time to one of NUM_SLV slaves and returns the
// slave response. Decode misses and slave timeouts answer with DEF_RDATA,
// pulse err_o and update the sticky err_addr_o / err_cause_o fields.
//   clk_i   - single clock
//   rst_n_i - asynchronous active-low reset
//   bus     - natv_bus_router_if.slave (core, slave and error signals)
// Legal NUM_SLV range is 2..8. TIMEOUT_CYC = 0 disables the slave timeout.
// ---------------------------------------------------------------------------
module natv_bus_router #(
    parameter int          NUM_SLV     = 4,
    parameter logic [31:0] SLV_BASE [NUM_SLV] = natv_bus_pkg::DEF_SLV_BASE,
    parameter logic [31:0] SLV_MASK [NUM_SLV] = natv_bus_pkg::DEF_SLV_MASK,
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [31:0] DEF_RDATA   = natv_bus_pkg::DEF_RDATA
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    natv_bus_router_if.slave bus
);
    import natv_bus_pkg::*;

    localparam int          IDX_W   = $clog2(NUM_SLV);
    localparam bit          TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

    generate
        if (NUM_SLV < 2 || NUM_SLV > 8) begin : g_bad_num_slv
            $error("natv_bus_router: NUM_SLV must be within 2..8");
        end
    endgenerate

    state_e             state_r;
    logic [IDX_W-1:0]   idx_r;
    logic [31:0]        cnt_r;
    logic [NUM_SLV-1:0] slv_valid_r;
    logic [31:0]        slv_addr_r;
    logic [31:0]        slv_wdata_r;
    logic [3:0]         slv_wstrb_r;
    logic               core_ready_r;
    logic [31:0]        core_rdata_r;
    logic               err_r;
    logic [31:0]        err_addr_r;
    err_cause_e         err_cause_r;

    logic [NUM_SLV-1:0] dec_hit_s;
    logic [IDX_W-1:0]   dec_idx_s;
    logic               dec_miss_s;
    logic               start_s;
    logic               miss_s;
    logic               done_s;
    logic               timeout_s;
    logic               err_evt_s;

    natv_bus_addr_dec #(
        .NUM_SLV  (NUM_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_addr_dec (
        .addr (bus.core_addr_i),
        .hit  (dec_hit_s),
        .idx  (dec_idx_s),
        .miss (dec_miss_s)
    );

    // Per-cycle events: request accepted, decode miss, slave done, timeout.
    // Ready from the selected slave is checked first so it beats a timeout.
    always_comb begin
        start_s   = 1'b0;
        miss_s    = 1'b0;
        done_s    = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                start_s = bus.core_valid_i & ~dec_miss_s;
                miss_s  = bus.core_valid_i &  dec_miss_s;
            end
            ST_REQ: begin
                done_s    = bus.slv_ready_i[idx_r];
                timeout_s = TO_EN && !done_s && (cnt_r == TO_LAST);
            end
            default: begin
                // RESP and unused encodings raise no events
            end
        endcase
    end

    assign err_evt_s = miss_s | timeout_s;

    // Main FSM: request registers, slave valid, timeout counter, response.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_r      <= ST_IDLE;
            idx_r        <= '0;
            cnt_r        <= 32'd0;
            slv_valid_r  <= '0;
            slv_addr_r   <= 32'd0;
            slv_wdata_r  <= 32'd0;
            slv_wstrb_r  <= 4'd0;
            core_ready_r <= 1'b0;
            core_rdata_r <= 32'd0;
        end else begin
            core_ready_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r     <= ST_REQ;
                        idx_r       <= dec_idx_s;
                        slv_valid_r <= dec_hit_s;
                        slv_addr_r  <= bus.core_addr_i;
                        slv_wdata_r <= bus.core_wdata_i;
                        slv_wstrb_r <= bus.core_wstrb_i;
                        cnt_r       <= 32'd0;
                    end else if (miss_s) begin
                        state_r      <= ST_RESP;
                        core_ready_r <= 1'b1;
                        core_rdata_r <= DEF_RDATA;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (done_s) begin
                        state_r      <= ST_RESP;
                        slv_valid_r  <= '0;
                        core_ready_r <= 1'b1;
                        core_rdata_r <= bus.slv_rdata_i[idx_r];
                    end else if (timeout_s) begin
                        state_r      <= ST_RESP;
                        slv_valid_r  <= '0;
                        core_ready_r <= 1'b1;
                        core_rdata_r <= DEF_RDATA;
                    end else begin
                        // with the timeout disabled the counter may wrap harmlessly
                        cnt_r <= cnt_r + 32'd1;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    slv_valid_r <= '0;
                end
            endcase
        end
    end

    // Error pulse and sticky error fields; a new error beats a clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            err_r       <= 1'b0;
            err_addr_r  <= 32'd0;
            err_cause_r <= ERR_NONE;
        end else begin
            err_r <= err_evt_s;
            if (miss_s) begin
                err_addr_r  <= bus.core_addr_i;
                err_cause_r <= ERR_MISS;
            end else if (timeout_s) begin
                err_addr_r  <= slv_addr_r;
                err_cause_r <= ERR_TIMEOUT;
            end else if (bus.err_clr_i) begin
                err_addr_r  <= 32'd0;
                err_cause_r <= ERR_NONE;
            end else begin
                err_addr_r  <= err_addr_r;
                err_cause_r <= err_cause_r;
            end
        end
    end

    assign bus.core_ready_o = core_ready_r;
    assign bus.core_rdata_o = core_rdata_r;
    assign bus.slv_valid_o  = slv_valid_r;
    assign bus.slv_addr_o   = slv_addr_r;
    assign bus.slv_wdata_o  = slv_wdata_r;
    assign bus.slv_wstrb_o  = slv_wstrb_r;
    assign bus.err_o        = err_r;
    assign bus.err_addr_o   = err_addr_r;
    assign bus.err_cause_o  = err_cause_r;

endmodule

// File: tb/tb_natv_bus_router.sv
// ---------------------------------------------------------------------------
// tb_natv_bus_router
// Directed bench for natv_bus_router (4 slaves, TIMEOUT_CYC = 8). A
// transaction-level model sets the expected outputs of every cycle from the
// address map and the slave answer latency; a negedge compare process checks
// the DUT against it, and literal expectations pin latency/data/error results.
// ---------------------------------------------------------------------------
module tb_natv_bus_router;

    localparam int          NS  = 4;
    localparam int          TO  = 8;
    localparam logic [31:0] DEF = 32'hDEAD_BEEF;
    localparam logic [31:0] BASE [NS] = '{32'h0000_0000, 32'h0300_0000, 32'h0400_0000, 32'h0800_0000};
    localparam logic [31:0] MASK [NS] = '{32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF80_0000};

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    natv_bus_router_if #(.NUM_SLV(NS)) bus ();

    natv_bus_router #(
        .NUM_SLV     (NS),
        .SLV_BASE    (BASE),
        .SLV_MASK    (MASK),
        .TIMEOUT_CYC (TO),
        .DEF_RDATA   (DEF)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // expected outputs for the current cycle
    logic          e_ready = 1'b0;
    logic [31:0]   e_rdata = 32'd0;
    logic [NS-1:0] e_valid = '0;
    logic [31:0]   e_addr  = 32'd0;
    logic [31:0]   e_wdata = 32'd0;
    logic [3:0]    e_wstrb = 4'd0;
    logic          e_err   = 1'b0;
    logic [31:0]   e_eaddr = 32'd0;
    logic [1:0]    e_ecause = 2'd0;

    bit chk_en = 1'b0;
    int n_chk  = 0;
    int n_pass = 0;

    // per-transaction observations
    int          start_cyc = 0;
    int          rdy_cnt   = 0;
    int          rdy_cyc   = 0;
    logic [31:0] rdy_data  = 32'd0;
    int          vld_len   = 0;
    int          vld_first = -1;
    int          err_cnt   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %08h required %08h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Observation and cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (bus.core_ready_o === 1'b1) begin
            rdy_cnt++;
            rdy_cyc  = cyc;
            rdy_data = bus.core_rdata_o;
        end
        if (bus.slv_valid_o !== '0) begin
            vld_len++;
            if (vld_first < 0) vld_first = cyc;
        end
        if (bus.err_o === 1'b1) err_cnt++;
        if (chk_en) begin
            chk("core_ready", 32'(bus.core_ready_o), 32'(e_ready));
            chk("core_rdata", bus.core_rdata_o, e_rdata);
            chk("slv_valid", 32'(bus.slv_valid_o), 32'(e_valid));
            chk("err_pulse", 32'(bus.err_o), 32'(e_err));
            chk("err_addr", bus.err_addr_o, e_eaddr);
            chk("err_cause", 32'(bus.err_cause_o), 32'(e_ecause));
            if (e_valid != '0) begin
                chk("slv_addr", bus.slv_addr_o, e_addr);
                chk("slv_wdata", bus.slv_wdata_o, e_wdata);
                chk("slv_wstrb", 32'(bus.slv_wstrb_o), 32'(e_wstrb));
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(bus.core_ready_o), 32'd0);
        chk({tag, "_rdata"}, bus.core_rdata_o, 32'd0);
        chk({tag, "_valid"}, 32'(bus.slv_valid_o), 32'd0);
        chk({tag, "_saddr"}, bus.slv_addr_o, 32'd0);
        chk({tag, "_swdata"}, bus.slv_wdata_o, 32'd0);
        chk({tag, "_swstrb"}, 32'(bus.slv_wstrb_o), 32'd0);
        chk({tag, "_err"}, 32'(bus.err_o), 32'd0);
        chk({tag, "_eaddr"}, bus.err_addr_o, 32'd0);
        chk({tag, "_ecause"}, 32'(bus.err_cause_o), 32'd0);
    endtask

    // Slaves other than 'sel' answer ready with junk data (must be ignored).
    task automatic drive_noise(input int sel);
        for (int j = 0; j < NS; j++) begin
            bus.slv_ready_i[j] = (j != sel);
            bus.slv_rdata_i[j] = 32'hBAD0_0000 | 32'(j);
        end
    endtask

    // One core transaction. lat = REQ cycle in which the slave answers
    // (1 = first REQ cycle); 0 = the slave never answers.
    task automatic txn(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                       input int lat, input logic [31:0] rd, input bit drop_valid, input bit clr);
        int            k;
        bit            miss;
        bit            tmo;
        int            nreq;
        logic [NS-1:0] oh;
        k    = 0;
        miss = 1'b1;
        for (int j = 0; j < NS; j++) begin
            if (miss && ((a & MASK[j]) == BASE[j])) begin
                k    = j;
                miss = 1'b0;
            end
        end
        oh    = '0;
        oh[k] = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc; rdy_cnt = 0; vld_len = 0; vld_first = -1; err_cnt = 0;
        bus.core_valid_i = 1'b1; bus.core_addr_i = a; bus.core_wdata_i = wd; bus.core_wstrb_i = ws;
        bus.err_clr_i = clr;
        bus.slv_ready_i = '0;
        e_ready = 1'b0; e_err = 1'b0; e_valid = '0;
        if (miss) begin
            @(posedge clk); #1;
            bus.core_valid_i = 1'b0; bus.err_clr_i = 1'b0;
            e_ready = 1'b1; e_rdata = DEF; e_err = 1'b1; e_eaddr = a; e_ecause = 2'd1;
        end else begin
            tmo  = !(lat >= 1 && lat <= TO);
            nreq = tmo ? TO : lat;
            for (int c = 1; c <= nreq; c++) begin
                @(posedge clk); #1;
                if (drop_valid) bus.core_valid_i = 1'b0;
                bus.err_clr_i = 1'b0;
                drive_noise(k);
                if (c == lat) begin
                    bus.slv_ready_i[k] = 1'b1;
                    bus.slv_rdata_i[k] = rd;
                end
                e_valid = oh; e_addr = a; e_wdata = wd; e_wstrb = ws;
            end
            @(posedge clk); #1;
            bus.core_valid_i = 1'b0;
            bus.slv_ready_i  = '1;
            e_valid = '0; e_ready = 1'b1; e_rdata = tmo ? DEF : rd; e_err = tmo;
            if (tmo) begin
                e_eaddr = a; e_ecause = 2'd2;
            end
        end
        @(posedge clk); #1;
        bus.slv_ready_i = '0;
        e_ready = 1'b0; e_err = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus.core_valid_i = 1'b0; bus.core_addr_i = 32'd0; bus.core_wdata_i = 32'd0;
        bus.core_wstrb_i = 4'd0; bus.slv_ready_i = '0; bus.err_clr_i = 1'b0;
        for (int j = 0; j < NS; j++) bus.slv_rdata_i[j] = 32'd0;
        #2;
        chk_all_zero("reset");
        #10;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // read to slave 1, answered in the first REQ cycle
        txn(32'h0300_0010, 32'h0, 4'h0, 1, 32'h1234_5678, 1'b0, 1'b0);
        chk("rd_latency", 32'(rdy_cyc - start_cyc), 32'd2);
        chk("rd_data", rdy_data, 32'h1234_5678);
        chk("rd_valid_start", 32'(vld_first - start_cyc), 32'd1);
        chk("rd_valid_len", 32'(vld_len), 32'd1);

        // write to slave 3, answered after 5 cycles
        txn(32'h0800_0004, 32'hA5A5_A5A5, 4'hF, 5, 32'h5555_0003, 1'b0, 1'b0);
        chk("wr_valid_len", 32'(vld_len), 32'd5);
        chk("wr_ready_pulses", 32'(rdy_cnt), 32'd1);
        chk("wr_no_err", 32'(err_cnt), 32'd0);

        // decode miss
        txn(32'h0500_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0);
        chk("miss_latency", 32'(rdy_cyc - start_cyc), 32'd1);
        chk("miss_data", rdy_data, 32'hDEAD_BEEF);
        chk("miss_err_pulses", 32'(err_cnt), 32'd1);
        chk("miss_no_valid", 32'(vld_len), 32'd0);
        chk("miss_cause", 32'(bus.err_cause_o), 32'd1);
        chk("miss_addr", bus.err_addr_o, 32'h0500_0000);

        // slave 0 never answers -> timeout
        txn(32'h0000_0100, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0);
        chk("to_valid_len", 32'(vld_len), 32'd8);
        chk("to_latency", 32'(rdy_cyc - start_cyc), 32'd9);
        chk("to_data", rdy_data, 32'hDEAD_BEEF);
        chk("to_cause", 32'(bus.err_cause_o), 32'd2);
        chk("to_addr", bus.err_addr_o, 32'h0000_0100);

        // slave 0 answers in the last allowed cycle -> ready wins
        txn(32'h0000_0200, 32'h0, 4'h0, 8, 32'hCAFE_0008, 1'b0, 1'b0);
        chk("edge_valid_len", 32'(vld_len), 32'd8);
        chk("edge_data", rdy_data, 32'hCAFE_0008);
        chk("edge_no_err", 32'(err_cnt), 32'd0);

        // core_valid_i dropped during REQ still completes
        txn(32'h0400_0008, 32'h0F0F_0F0F, 4'h3, 3, 32'h7777_0002, 1'b1, 1'b0);
        chk("drop_ready_pulses", 32'(rdy_cnt), 32'd1);
        chk("drop_data", rdy_data, 32'h7777_0002);

        // miss with a coincident clear: the new error wins
        txn(32'h0900_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b1);
        chk("clrwin_cause", 32'(bus.err_cause_o), 32'd1);
        chk("clrwin_addr", bus.err_addr_o, 32'h0900_0000);

        // reset in the middle of a request to slave 2
        @(posedge clk); #1;
        bus.core_valid_i = 1'b1; bus.core_addr_i = 32'h0400_0020;
        bus.core_wdata_i = 32'h1111_2222; bus.core_wstrb_i = 4'h1;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            e_valid = 4'b0100; e_addr = 32'h0400_0020; e_wdata = 32'h1111_2222; e_wstrb = 4'h1;
        end
        #2;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk_all_zero("midrst");
        bus.core_valid_i = 1'b0;
        e_ready = 1'b0; e_rdata = 32'd0; e_valid = '0; e_err = 1'b0; e_eaddr = 32'd0; e_ecause = 2'd0;
        @(posedge clk); #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;

        txn(32'h0300_0000, 32'h0, 4'h0, 2, 32'h0BAD_F00D, 1'b0, 1'b0);
        chk("postrst_pulses", 32'(rdy_cnt), 32'd1);
        chk("postrst_data", rdy_data, 32'h0BAD_F00D);

        // set a sticky error and clear it
        txn(32'h0600_0000, 32'h0, 4'h0, 0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.err_clr_i = 1'b1;
        @(posedge clk); #1;
        bus.err_clr_i = 1'b0;
        e_eaddr = 32'd0; e_ecause = 2'd0;
        @(posedge clk); #1;
        chk("clr_cause", 32'(bus.err_cause_o), 32'd0);
        chk("clr_addr", bus.err_addr_o, 32'd0);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/natv_bus_router.md
NATV_BUS_ROUTER -- requirements
Module: natv_bus_router

Interface
REQ-001 Parameter NUM_SLV, default 4, number of slave ports; the legal range SHALL be 2..8.
REQ-002 Parameter SLV_BASE, default {32'h0000_0000, 32'h0300_0000, 32'h0400_0000, 32'h0800_0000}, per-slave base address array [NUM_SLV].
REQ-003 Parameter SLV_MASK, default {32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF80_0000}, per-slave compare mask array [NUM_SLV].
REQ-004 Parameter TIMEOUT_CYC, default 1024, gives the slave wait limit in cycles; a value of 0 SHALL disable the timeout.
REQ-005 Parameter DEF_RDATA, default 32'hDEAD_BEEF, is the read data returned on decode miss or timeout.
REQ-006 clk_i  in  1  single clock; the block SHALL have exactly one clock and one reset.
REQ-007 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-008 core_valid_i  in  1  master request valid, held until core_ready_o.
REQ-009 core_addr_i / core_wdata_i  in  32 / 32  master address and write data.
REQ-010 core_wstrb_i  in  4  byte strobes; 0 means read.
REQ-011 core_rdata_o / core_ready_o  out  32 / 1  response data and single-cycle ready.
REQ-012 slv_valid_o  out  NUM_SLV  one-hot slave request.
REQ-013 slv_addr_o / slv_wdata_o / slv_wstrb_o  out  32 / 32 / 4  registered request fields, shared by all slaves.
REQ-014 slv_rdata_i / slv_ready_i  in  NUM_SLV x 32 / NUM_SLV  per-slave response.
REQ-015 err_o  out  1  one-cycle pulse on a miss or timeout response.
REQ-016 err_addr_o  out  32  sticky address of the last erroneous access.
REQ-017 err_cause_o  out  2  sticky cause: 0 none, 1 miss, 2 timeout.
REQ-018 err_clr_i  in  1  clears err_addr_o and err_cause_o.

Function
REQ-019 A slave k SHALL be hit when (core_addr_i & SLV_MASK[k]) == SLV_BASE[k]; on overlapping hits the lowest index SHALL win.
REQ-020 The FSM SHALL have the states IDLE, REQ and RESP.
REQ-021 IDLE with core_valid_i and a hit: register addr, wdata, wstrb and index; next state REQ; the selected slv_valid_o bit SHALL be high from the next cycle.
REQ-022 IDLE with core_valid_i and a miss: next state RESP with rdata=DEF_RDATA, cause=miss; no slv_valid_o bit SHALL assert.
REQ-023 REQ: slv_valid_o[idx] SHALL stay high and all request fields SHALL stay stable until slv_ready_i[idx]=1; then capture slv_rdata_i[idx], drop slv_valid_o and go to RESP.
REQ-024 RESP: core_ready_o=1 and core_rdata_o SHALL be valid for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-025 Latency: a hit answered in the first REQ cycle SHALL give core_ready_o in cycle 2, with core_valid_i first high in cycle 0; a miss SHALL give core_ready_o in cycle 1.
REQ-026 A timeout counter SHALL clear on entry to REQ and increment each REQ cycle; when it reaches TIMEOUT_CYC-1 without ready, the block SHALL drop slv_valid_o and go to RESP with DEF_RDATA and cause=timeout.
REQ-027 When slv_ready_i[idx] and timeout occur in the same cycle, the ready SHALL win and no error SHALL be raised.
REQ-028 slv_ready_i from non-selected slaves, and any slv_ready_i outside REQ, SHALL be ignored.
REQ-029 core_rdata_o SHALL hold its last value outside RESP; writes SHALL return the captured slave rdata (don't-care to the master).
REQ-030 err_o SHALL pulse in the RESP cycle of a miss or timeout; err_addr_o and err_cause_o SHALL update in that same cycle.
REQ-031 When err_clr_i coincides with a new error, the new error SHALL win.
REQ-032 If core_valid_i drops during REQ (a protocol violation), the transaction SHALL still complete normally.
REQ-033 Exactly one transaction SHALL be outstanding at a time; core_valid_i SHALL be sampled only in IDLE.

Reset
REQ-034 On rst_n_i low, asynchronously: state=IDLE, all outputs=0, and the counter, index and sticky error registers=0.
REQ-035 A reset in mid-transaction SHALL drop slv_valid_o immediately; after release the block SHALL be in IDLE.

Structure
REQ-036 Package natv_bus_pkg SHALL hold the FSM state enum, the error-cause enum, DEF_RDATA and the default base/mask constants.
REQ-037 The address decode SHALL be a combinational sub-module natv_bus_addr_dec that outputs a one-hot hit vector, an encoded index and a miss flag.

Verification
REQ-038 Read at 0x0300_0010, slave 1 ready in cycle 1 with rdata 0x1234_5678 -> slv_valid_o=4'b0010 in cycle 1; core_ready_o in cycle 2 with 0x1234_5678.
REQ-039 Write at 0x0800_0004 with wdata 0xA5A5_A5A5 and wstrb 4'hF, slave 3 ready after 5 cycles -> slv_wdata_o stable for all 5 cycles; one core_ready_o pulse.
REQ-040 Access to 0x0500_0000 -> core_ready_o in cycle 1 with 0xDEAD_BEEF; err_o pulses; err_cause_o=1; err_addr_o=0x0500_0000; no slv_valid_o.
REQ-041 TIMEOUT_CYC=8, slave 0 never ready -> slv_valid_o drops after 8 cycles; DEF_RDATA returned; err_cause_o=2. A repeat with ready in the 8th cycle -> slave data returned and no error.
REQ-042 rst_n_i pulsed low during REQ -> all outputs 0 at once; the next request after release completes normally; err_clr_i clears the sticky error fields.
